// File: rtl/i2s_codec_master.sv
// Codec-side I2S master: divides clk_clk into BCLK/LRCK and moves stereo samples over ADCDAT/DACDAT.
// Outputs change on the BCLK event cycle; tx_valid waits on tx_ready (1-deep buffer), rx has no backpressure.
module i2s_codec_master #(
  parameter int CLK_DIV = 12,
  parameter int SLOT_W  = 32,
  parameter int DATA_W  = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  output logic              bclk,
  output logic              daclrck,
  output logic              adclrck,
  output logic              adcdat,
  input  logic              dacdat,
  input  logic [DATA_W-1:0] tx_left,
  input  logic [DATA_W-1:0] tx_right,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic [DATA_W-1:0] rx_left,
  output logic [DATA_W-1:0] rx_right,
  output logic              rx_valid
);
  localparam int DVW = $clog2(CLK_DIV);
  localparam int BW  = $clog2(2 * SLOT_W);
  localparam int PW  = $clog2(SLOT_W);
  localparam int XW  = 2 ** PW;

  logic [DVW-1:0]    div_cnt_q, div_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              bclk_q, bclk_d;
  logic              lrck_q, lrck_d;
  logic              adcdat_q, adcdat_d;
  logic              buf_full_q, buf_full_d;
  logic [DATA_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic [DATA_W-1:0] pair_l_q, pair_l_d, pair_r_q, pair_r_d;
  logic              tx_underrun_q, tx_underrun_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d, rx_hold_q, rx_hold_d;
  logic              rx_done_q, rx_done_d;
  logic [DATA_W-1:0] rx_left_q, rx_left_d, rx_right_q, rx_right_d;
  logic              rx_valid_q, rx_valid_d;

  logic              tc, rise, fall, frame_start;
  logic [BW-1:0]     bit_nxt;
  logic              right_new, right_cur, p_new_ok, p_cur_ok;
  logic [PW-1:0]     p_new, p_cur, tx_idx;
  logic [XW-1:0]     tx_word;
  logic [DATA_W-1:0] rx_shifted;

  always_comb begin
    tc          = (div_cnt_q == DVW'(CLK_DIV - 1));
    rise        = tc && !bclk_q;
    fall        = tc && bclk_q;
    bit_nxt     = (bit_cnt_q == BW'(2 * SLOT_W - 1)) ? '0 : bit_cnt_q + 1'b1;
    frame_start = fall && (bit_nxt == '0);
    right_new   = (bit_nxt >= BW'(SLOT_W));
    p_new       = right_new ? PW'(bit_nxt - BW'(SLOT_W)) : PW'(bit_nxt);
    right_cur   = (bit_cnt_q >= BW'(SLOT_W));
    p_cur       = right_cur ? PW'(bit_cnt_q - BW'(SLOT_W)) : PW'(bit_cnt_q);
    p_new_ok    = (p_new != '0) && (p_new <= PW'(DATA_W));
    p_cur_ok    = (p_cur != '0) && (p_cur <= PW'(DATA_W));
    // Zero-extended so the slot-position index never runs past the word.
    tx_word     = {{(XW - DATA_W){1'b0}}, (right_new ? pair_r_q : pair_l_q)};
    tx_idx      = PW'(DATA_W) - p_new;
    rx_shifted  = {rx_sh_q[DATA_W-2:0], dacdat};
  end

  always_comb begin
    div_cnt_d     = tc ? '0 : div_cnt_q + 1'b1;
    bclk_d        = bclk_q ^ tc;
    bit_cnt_d     = bit_cnt_q;
    lrck_d        = lrck_q;
    adcdat_d      = adcdat_q;
    buf_full_d    = buf_full_q;
    buf_l_d       = buf_l_q;
    buf_r_d       = buf_r_q;
    pair_l_d      = pair_l_q;
    pair_r_d      = pair_r_q;
    tx_underrun_d = 1'b0;
    if (fall) begin
      bit_cnt_d = bit_nxt;
      lrck_d    = right_new;
      adcdat_d  = p_new_ok ? tx_word[tx_idx] : 1'b0;
    end
    // Buffer state is sampled before this cycle's write, so a write at frame start still underruns.
    if (frame_start) begin
      if (buf_full_q) begin
        pair_l_d   = buf_l_q;
        pair_r_d   = buf_r_q;
        buf_full_d = 1'b0;
      end else begin
        tx_underrun_d = 1'b1;
      end
    end
    if (tx_valid && !buf_full_q) begin
      buf_l_d    = tx_left;
      buf_r_d    = tx_right;
      buf_full_d = 1'b1;
    end
  end

  always_comb begin
    rx_sh_d    = rx_sh_q;
    rx_hold_d  = rx_hold_q;
    rx_done_d  = 1'b0;
    rx_valid_d = rx_done_q;
    rx_left_d  = rx_left_q;
    rx_right_d = rx_right_q;
    if (rise && p_cur_ok) begin
      rx_sh_d = rx_shifted;
      if (p_cur == PW'(DATA_W)) begin
        if (right_cur) rx_done_d = 1'b1;
        else           rx_hold_d = rx_shifted;
      end
    end
    if (rx_done_q) begin
      rx_left_d  = rx_hold_q;
      rx_right_d = rx_sh_q;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      div_cnt_q     <= '0;
      bit_cnt_q     <= BW'(2 * SLOT_W - 1);
      bclk_q        <= 1'b0;
      lrck_q        <= 1'b1;
      adcdat_q      <= 1'b0;
      buf_full_q    <= 1'b0;
      buf_l_q       <= '0;
      buf_r_q       <= '0;
      pair_l_q      <= '0;
      pair_r_q      <= '0;
      tx_underrun_q <= 1'b0;
      rx_sh_q       <= '0;
      rx_hold_q     <= '0;
      rx_done_q     <= 1'b0;
      rx_left_q     <= '0;
      rx_right_q    <= '0;
      rx_valid_q    <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      bclk_q        <= bclk_d;
      lrck_q        <= lrck_d;
      adcdat_q      <= adcdat_d;
      buf_full_q    <= buf_full_d;
      buf_l_q       <= buf_l_d;
      buf_r_q       <= buf_r_d;
      pair_l_q      <= pair_l_d;
      pair_r_q      <= pair_r_d;
      tx_underrun_q <= tx_underrun_d;
      rx_sh_q       <= rx_sh_d;
      rx_hold_q     <= rx_hold_d;
      rx_done_q     <= rx_done_d;
      rx_left_q     <= rx_left_d;
      rx_right_q    <= rx_right_d;
      rx_valid_q    <= rx_valid_d;
    end
  end

  assign bclk        = bclk_q;
  assign daclrck     = lrck_q;
  assign adclrck     = lrck_q;
  assign adcdat      = adcdat_q;
  assign tx_ready    = !buf_full_q;
  assign tx_underrun = tx_underrun_q;
  assign rx_left     = rx_left_q;
  assign rx_right    = rx_right_q;
  assign rx_valid    = rx_valid_q;
endmodule

// File: tb/tb_i2s_codec_master.sv
// Loopback bench for i2s_codec_master: frame plan table drives tx pairs, scoreboards check adcdat frames and rx pairs.
module tb_i2s_codec_master;
  localparam int CLK_DIV    = 12;
  localparam int FRAME      = 1536;
  localparam int FIRST_FALL = 24;
  localparam int RX_OFS     = 1165;
  localparam int NF         = 8;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        bclk, daclrck, adclrck, adcdat, dacdat;
  logic [15:0] tx_left = '0, tx_right = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, tx_underrun, rx_valid;
  logic [15:0] rx_left, rx_right;

  int cyc;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        unr;
    logic [15:0] l;
    logic [15:0] r;
  } exp_t;

  typedef struct {
    logic        offer;
    int          at_edge;
    logic [15:0] l;
    logic [15:0] r;
    int          acc_edge;
    logic        unr;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;

  exp_t sb_q[$];
  exp_t rx_q[$];
  vec_t vecs[NF];

  assign dacdat = adcdat;

  i2s_codec_master dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .bclk(bclk), .daclrck(daclrck), .adclrck(adclrck),
    .adcdat(adcdat), .dacdat(dacdat),
    .tx_left(tx_left), .tx_right(tx_right), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun),
    .rx_left(rx_left), .rx_right(rx_right), .rx_valid(rx_valid)
  );

  always #5 clk_clk = ~clk_clk;

  always @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) cyc <= 0;
    else                cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc < target && n < 20000) begin
      tick();
      n++;
    end
    if (cyc < target) chk("wait_cyc timeout", 64'(cyc), 64'(target));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " bclk"}, 64'(bclk), 64'd0);
    chk({tag, " daclrck"}, 64'(daclrck), 64'd1);
    chk({tag, " adclrck"}, 64'(adclrck), 64'd1);
    chk({tag, " adcdat"}, 64'(adcdat), 64'd0);
    chk({tag, " tx_ready"}, 64'(tx_ready), 64'd1);
    chk({tag, " tx_underrun"}, 64'(tx_underrun), 64'd0);
    chk({tag, " rx_valid"}, 64'(rx_valid), 64'd0);
    chk({tag, " rx_pair"}, {32'h0, rx_left, rx_right}, 64'd0);
  endtask

  task automatic check_restart(input string tag);
    int n = 0;
    while (!bclk && n < 100) begin tick(); n++; end
    chk({tag, " first bclk rise cycle"}, 64'(cyc), 64'd12);
    n = 0;
    while (daclrck && n < 100) begin tick(); n++; end
    chk({tag, " first daclrck fall cycle"}, 64'(cyc), 64'd24);
  endtask

  task automatic driver();
    for (int k = 0; k < NF; k++) begin
      exp_t e;
      int n;
      int acc;
      e.unr = vecs[k].unr;
      e.l   = vecs[k].el;
      e.r   = vecs[k].er;
      sb_q.push_back(e);
      rx_q.push_back(e);
      if (vecs[k].offer) begin
        wait_cyc(vecs[k].at_edge - 1);
        tx_left  = vecs[k].l;
        tx_right = vecs[k].r;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 5000) begin tick(); n++; end
        tick();
        acc = cyc;
        tx_valid = 1'b0;
        chk($sformatf("accept edge row %0d", k), 64'(acc), 64'(vecs[k].acc_edge));
      end
    end
  endtask

  task automatic frame_monitor();
    for (int k = 0; k < NF; k++) begin
      int f;
      exp_t e;
      logic [63:0] cap_d, cap_l, exp_d;
      f = FIRST_FALL + k * FRAME;
      wait_cyc(f);
      if (sb_q.size() == 0) begin
        chk("frame scoreboard empty", 64'd1, 64'd0);
        continue;
      end
      e = sb_q.pop_front();
      chk($sformatf("tx_underrun frame %0d", k), 64'(tx_underrun), 64'(e.unr));
      cap_d[63] = adcdat;
      cap_l[63] = daclrck;
      tick();
      chk($sformatf("tx_underrun width frame %0d", k), 64'(tx_underrun), 64'd0);
      for (int b = 1; b < 64; b++) begin
        wait_cyc(f + 2 * CLK_DIV * b);
        cap_d[63-b] = adcdat;
        cap_l[63-b] = daclrck;
      end
      exp_d = {1'b0, e.l, 15'h0, 1'b0, e.r, 15'h0};
      chk($sformatf("adcdat frame %0d", k), cap_d, exp_d);
      chk($sformatf("daclrck frame %0d", k), cap_l, {32'h0, 32'hFFFF_FFFF});
    end
  endtask

  task automatic rx_monitor();
    for (int k = 0; k < NF; k++) begin
      int n = 0;
      exp_t e;
      while (!rx_valid && n < 3000) begin tick(); n++; end
      if (!rx_valid) begin
        chk($sformatf("rx_valid timeout frame %0d", k), 64'd0, 64'd1);
        continue;
      end
      if (rx_q.size() == 0) begin
        chk("rx scoreboard empty", 64'd1, 64'd0);
        continue;
      end
      e = rx_q.pop_front();
      chk($sformatf("rx_valid cycle frame %0d", k), 64'(cyc), 64'(FIRST_FALL + k * FRAME + RX_OFS));
      chk($sformatf("rx pair frame %0d", k), {32'h0, rx_left, rx_right}, {32'h0, e.l, e.r});
      tick();
      chk($sformatf("rx_valid width frame %0d", k), 64'(rx_valid), 64'd0);
    end
  endtask

  initial begin
    logic saw;
    vecs[0] = '{1'b1, 1,                    16'hA5F0, 16'h0F5A, 1,                    1'b0, 16'hA5F0, 16'h0F5A};
    vecs[1] = '{1'b0, 0,                    16'h0000, 16'h0000, 0,                    1'b1, 16'hA5F0, 16'h0F5A};
    vecs[2] = '{1'b1, 24 + FRAME + 700,     16'h1234, 16'h8001, 24 + FRAME + 700,     1'b0, 16'h1234, 16'h8001};
    vecs[3] = '{1'b1, 24 + 3 * FRAME,       16'hFFFF, 16'h0000, 24 + 3 * FRAME,       1'b1, 16'h1234, 16'h8001};
    vecs[4] = '{1'b0, 0,                    16'h0000, 16'h0000, 0,                    1'b0, 16'hFFFF, 16'h0000};
    vecs[5] = '{1'b1, 24 + 4 * FRAME + 100, 16'h8000, 16'h0001, 24 + 4 * FRAME + 100, 1'b0, 16'h8000, 16'h0001};
    vecs[6] = '{1'b1, 24 + 4 * FRAME + 101, 16'h7FFE, 16'hC3C3, 24 + 5 * FRAME + 1,   1'b0, 16'h7FFE, 16'hC3C3};
    vecs[7] = '{1'b0, 0,                    16'h0000, 16'h0000, 0,                    1'b1, 16'h7FFE, 16'hC3C3};

    repeat (3) tick();
    check_reset_vals("reset");
    reset_reset_n = 1'b1;

    fork
      check_restart("power-on");
      driver();
      frame_monitor();
      rx_monitor();
    join

    // Fill the buffer in frame 8, then reset at left slot position 8.
    wait_cyc(FIRST_FALL + 8 * FRAME + 49);
    tx_left  = 16'hDEAD;
    tx_right = 16'hBEEF;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("buffer full before mid reset", 64'(tx_ready), 64'd0);
    wait_cyc(FIRST_FALL + 8 * FRAME + 200);
    reset_reset_n = 1'b0;
    #1;
    check_reset_vals("mid reset");
    saw = 1'b0;
    repeat (3) begin
      tick();
      if (rx_valid) saw = 1'b1;
    end
    reset_reset_n = 1'b1;
    check_restart("restart");
    chk("restart frame 0 underrun", 64'(tx_underrun), 64'd1);
    while (cyc < FIRST_FALL + RX_OFS - 1) begin
      tick();
      if (rx_valid) saw = 1'b1;
    end
    chk("no rx_valid around mid reset", 64'(saw), 64'd0);
    tick();
    chk("restart rx_valid", 64'(rx_valid), 64'd1);
    chk("restart rx pair", {32'h0, rx_left, rx_right}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end
endmodule
